// File: rtl/sm_clk_sequencer_pkg.sv
// Shared encodings for the schoolMIPS clock-enable sequencer: mode inputs and FSM state.
package sm_clk_sequencer_pkg;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StStep  = 2'b10,
    StBurst = 2'b11
  } seq_state_e;

endpackage

// File: rtl/sm_edge_rise.sv
// Rising-edge detector with a configurable reset value for the history flop.
module sm_edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= RESET_VAL;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/sm_clk_sequencer.sv
// Clock-enable sequencer: halt / free-run / single-step / burst cpuTick generation.
// Optional breakpoint halt enabled by defining SM_CLK_SEQ_BREAKPOINT_EN.
module sm_clk_sequencer
  import sm_clk_sequencer_pkg::*;
#(
  parameter int unsigned SHIFT   = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         devide,
  input  logic [1:0]         mode,
  input  logic               stepReq,
  input  logic [BURST_W-1:0] burstLen,
  input  logic [31:0]        pc,
  input  logic [31:0]        bpAddr,
  output logic               cpuTick,
  output logic [1:0]         state,
  output logic [BURST_W-1:0] remaining,
  output logic               bpHit
);

  seq_state_e         r_state, w_state_next;
  logic [CNT_W-1:0]   r_cntr, w_cntr_next, w_mask;
  logic [BURST_W-1:0] r_remaining, w_remaining_next;
  logic               r_bp_hit, w_bp_hit_next;
  logic               w_step_rise, w_pre, w_active, w_bp_stop, w_tick;

  sm_edge_rise #(
    .RESET_VAL (1'b1)
  ) u_step_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (stepReq),
    .o_rise (w_step_rise)
  );

  assign w_mask = (CNT_W'(1) << (SHIFT + 32'(devide))) - CNT_W'(1);
  assign w_pre  = (r_cntr & w_mask) == w_mask;

  // Gating on mode here makes a mode change win over a coincident prescaler tick.
  assign w_active = (r_state == StRun   && mode == MODE_RUN) ||
                    (r_state == StBurst && mode == MODE_BURST);

`ifdef SM_CLK_SEQ_BREAKPOINT_EN
  assign w_bp_stop = w_active & w_pre & (pc == bpAddr);
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{pc, bpAddr};
  assign w_bp_stop   = 1'b0;
`endif

  assign w_tick = (r_state == StStep) | (w_active & w_pre & ~w_bp_stop);

  always_comb begin
    w_state_next     = r_state;
    w_cntr_next      = '0;
    w_remaining_next = r_remaining;
    w_bp_hit_next    = r_bp_hit;
    unique case (r_state)
      StIdle: begin
        if (w_step_rise && (mode == MODE_STEP || r_bp_hit)) begin
          w_state_next  = StStep;
          w_bp_hit_next = 1'b0;
        end else if (w_step_rise && mode == MODE_BURST && burstLen != '0 && !r_bp_hit) begin
          w_state_next     = StBurst;
          w_remaining_next = burstLen;
        end else if (mode == MODE_RUN && !r_bp_hit) begin
          w_state_next = StRun;
        end
      end
      StStep: w_state_next = StIdle;
      StRun: begin
        if (mode != MODE_RUN) begin
          w_state_next = StIdle;
        end else begin
          w_cntr_next = r_cntr + CNT_W'(1);
          if (w_bp_stop) begin
            w_state_next  = StIdle;
            w_bp_hit_next = 1'b1;
          end
        end
      end
      StBurst: begin
        if (mode != MODE_BURST) begin
          w_state_next     = StIdle;
          w_remaining_next = '0;
        end else begin
          w_cntr_next = r_cntr + CNT_W'(1);
          if (w_bp_stop) begin
            w_state_next     = StIdle;
            w_remaining_next = '0;
            w_bp_hit_next    = 1'b1;
          end else if (w_tick) begin
            if (r_remaining == BURST_W'(1)) begin
              w_state_next     = StIdle;
              w_remaining_next = '0;
            end else begin
              w_remaining_next = r_remaining - BURST_W'(1);
            end
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cntr      <= '0;
      r_remaining <= '0;
      r_bp_hit    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cntr      <= w_cntr_next;
      r_remaining <= w_remaining_next;
      r_bp_hit    <= w_bp_hit_next;
    end
  end

  assign cpuTick   = w_tick;
  assign state     = r_state;
  assign remaining = r_remaining;
  assign bpHit     = r_bp_hit;

endmodule

// File: tb/tb_sm_clk_sequencer.sv
// Directed bench for sm_clk_sequencer; expected tick cycles are queued and matched on each tick.
module tb_sm_clk_sequencer;
  import sm_clk_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  devide;
  logic [1:0]  mode;
  logic        stepReq;
  logic [7:0]  burstLen;
  logic [31:0] pc;
  logic [31:0] bpAddr;
  logic        cpuTick;
  logic [1:0]  state;
  logic [7:0]  remaining;
  logic        bpHit;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];
  int t;

  sm_clk_sequencer #(
    .SHIFT   (2),
    .CNT_W   (32),
    .BURST_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .devide    (devide),
    .mode      (mode),
    .stepReq   (stepReq),
    .burstLen  (burstLen),
    .pc        (pc),
    .bpAddr    (bpAddr),
    .cpuTick   (cpuTick),
    .state     (state),
    .remaining (remaining),
    .bpHit     (bpHit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal CPU: fetch address advances one word per tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= 32'h0;
    else if (cpuTick) pc <= pc + 32'd4;
  end

  // Every observed tick must match the oldest expected tick cycle.
  always @(negedge clk) begin
    if (rst_n && cpuTick) begin
      int exp_t;
      exp_t = -1;
      if (exp_q.size() > 0) exp_t = exp_q.pop_front();
      checks++;
      assert (cyc === exp_t) else begin
        failures++;
        $error("FAIL tick_cycle: got tick at cycle %0d, expected cycle %0d", cyc, exp_t);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    devide   = 4'd1;
    mode     = MODE_HALT;
    stepReq  = 1'b0;
    burstLen = 8'd0;
    bpAddr   = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'(StIdle));
    chk("reset_remaining", 32'(remaining), 32'd0);
    chk("reset_tick", 32'(cpuTick), 32'd0);
    chk("reset_bphit", 32'(bpHit), 32'd0);
    rst_n = 1'b1;
    wait_cyc(cyc + 2);

`ifdef SM_CLK_SEQ_BREAKPOINT_EN
    t = cyc;
    mode = MODE_RUN;
    exp_q.push_back(t + 8);
    exp_q.push_back(t + 16);
    exp_q.push_back(t + 24);
    exp_q.push_back(t + 32);
    wait_cyc(t + 41);
    chk("bp_state", 32'(state), 32'(StIdle));
    chk("bp_hit_set", 32'(bpHit), 32'd1);
    chk("bp_pc", pc, 32'h10);
    wait_cyc(t + 44);
    stepReq = 1'b1;
    exp_q.push_back(t + 45);
    wait_cyc(t + 46);
    chk("bp_hit_clear", 32'(bpHit), 32'd0);
    stepReq = 1'b0;
    exp_q.push_back(t + 54);
    wait_cyc(t + 56);
    mode = MODE_HALT;
    wait_cyc(t + 58);
    chk("bp_resume_halt", 32'(state), 32'(StIdle));
`endif

    // Free run: period 8 with SHIFT=2, devide=1.
    t = cyc;
    mode = MODE_RUN;
    exp_q.push_back(t + 8);
    exp_q.push_back(t + 16);
    exp_q.push_back(t + 24);
    wait_cyc(t + 1);
    chk("run_state", 32'(state), 32'(StRun));
    wait_cyc(t + 26);
    mode = MODE_HALT;
    wait_cyc(t + 27);
    chk("run_halt_state", 32'(state), 32'(StIdle));
    wait_cyc(t + 40);

    // Halt exactly on a prescaler hit: no tick.
    t = cyc;
    mode = MODE_RUN;
    wait_cyc(t + 8);
    mode = MODE_HALT;
    wait_cyc(t + 9);
    chk("halt_wins_state", 32'(state), 32'(StIdle));
    wait_cyc(t + 20);

    mode = MODE_STEP;
    for (int i = 0; i < 3; i++) begin
      t = cyc;
      stepReq = 1'b1;
      exp_q.push_back(t + 1);
      wait_cyc(t + 1);
      chk("step_state", 32'(state), 32'(StStep));
      wait_cyc(t + 2);
      stepReq = 1'b0;
      wait_cyc(t + 5);
    end
    t = cyc;
    stepReq = 1'b1;
    exp_q.push_back(t + 1);
    wait_cyc(t + 20);
    stepReq = 1'b0;
    wait_cyc(t + 23);
    chk("step_held_state", 32'(state), 32'(StIdle));

    mode = MODE_BURST;
    burstLen = 8'd5;
    t = cyc;
    stepReq = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(t + 8 * k);
    wait_cyc(t + 1);
    chk("burst_state", 32'(state), 32'(StBurst));
    chk("burst_rem5", 32'(remaining), 32'd5);
    stepReq = 1'b0;
    wait_cyc(t + 9);
    chk("burst_rem4", 32'(remaining), 32'd4);
    wait_cyc(t + 41);
    chk("burst_done_state", 32'(state), 32'(StIdle));
    chk("burst_done_rem", 32'(remaining), 32'd0);
    wait_cyc(t + 50);

    burstLen = 8'd0;
    t = cyc;
    stepReq = 1'b1;
    wait_cyc(t + 1);
    chk("burst0_state", 32'(state), 32'(StIdle));
    stepReq = 1'b0;
    wait_cyc(t + 20);

    burstLen = 8'd5;
    t = cyc;
    stepReq = 1'b1;
    exp_q.push_back(t + 8);
    exp_q.push_back(t + 16);
    wait_cyc(t + 1);
    stepReq = 1'b0;
    wait_cyc(t + 17);
    chk("abort_rem3", 32'(remaining), 32'd3);
    wait_cyc(t + 20);
    mode = MODE_HALT;
    wait_cyc(t + 21);
    chk("abort_state", 32'(state), 32'(StIdle));
    chk("abort_rem", 32'(remaining), 32'd0);
    wait_cyc(t + 35);

    // devide 3 -> 0 at cntr=10: next hit at cntr=11, then every 4.
    devide = 4'd3;
    t = cyc;
    mode = MODE_RUN;
    exp_q.push_back(t + 12);
    exp_q.push_back(t + 16);
    wait_cyc(t + 11);
    devide = 4'd0;
    wait_cyc(t + 18);
    mode = MODE_HALT;
    wait_cyc(t + 19);
    devide = 4'd1;
    chk("devide_halt_state", 32'(state), 32'(StIdle));
    wait_cyc(t + 30);

`ifndef SM_CLK_SEQ_BREAKPOINT_EN
    chk("bphit_tied", 32'(bpHit), 32'd0);
`endif

    mode = MODE_BURST;
    burstLen = 8'd5;
    t = cyc;
    stepReq = 1'b1;
    exp_q.push_back(t + 8);
    exp_q.push_back(t + 16);
    wait_cyc(t + 1);
    stepReq = 1'b0;
    wait_cyc(t + 18);
    chk("rst_pre_rem3", 32'(remaining), 32'd3);
    stepReq = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", 32'(state), 32'(StIdle));
    chk("rst_async_rem", 32'(remaining), 32'd0);
    chk("rst_async_tick", 32'(cpuTick), 32'd0);
    chk("rst_async_bphit", 32'(bpHit), 32'd0);
    wait_cyc(t + 21);
    rst_n = 1'b1;
    t = cyc;
    wait_cyc(t + 20);
    chk("rst_held_btn_state", 32'(state), 32'(StIdle));
    stepReq = 1'b0;
    mode = MODE_HALT;
    wait_cyc(t + 23);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
